fpu_fp_to_int_pipe: RTL and testbench

FPU_FP_TO_INT_PIPE -- requirements
Module: fpu_fp_to_int_pipe

---
 rtl/fpu_fp_to_int_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_fpu_fp_to_int_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fp_to_int_pipe.sv
// rtl/fpu_fp_to_int_pipe.sv - three-stage binary64 to integer conversion pipeline
//
// Purpose: converts an IEEE-754 binary64 operand to an OUT_W-bit signed or
// unsigned integer under one of four rounding modes, reporting invalid and
// inexact flags alongside the result. Three register stages, one result per
// cycle, with the whole pipeline frozen while the consumer back-pressures.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous reset, active-high
//   in_valid     operand present
//   in_ready     operand accepted this cycle (combinational: !stall)
//   src          binary64 operand
//   is_unsigned  1 = unsigned target, 0 = two's-complement target
//   rmode        00 truncate, 01 nearest-even, 10 floor, 11 ceil
//   out_valid    result present
//   out_ready    consumer accepts result
//   dst          integer result
//   flags        {invalid, inexact}, aligned with dst

module fpu_fp_to_int_pipe #(
  parameter int OUT_W   = 64,
  parameter int PIPE_ST = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      src,
  input  logic             is_unsigned,
  input  logic [1:0]       rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dst,
  output logic [1:0]       flags
);

  generate
    if (PIPE_ST != 3) begin : g_bad_pipe_st
      $error("fpu_fp_to_int_pipe: PIPE_ST must be 3");
    end
    if (OUT_W < 16 || OUT_W > 64) begin : g_bad_out_w
      $error("fpu_fp_to_int_pipe: OUT_W must be in 16..64");
    end
  endgenerate

  // Range limits expressed as 66-bit magnitudes so the rounded magnitude
  // can be compared without any wrap.
  localparam logic [65:0] UMAX     = (66'd1 << OUT_W) - 66'd1;
  localparam logic [65:0] SMAX     = (66'd1 << (OUT_W - 1)) - 66'd1;
  localparam logic [65:0] SMIN_MAG = 66'd1 << (OUT_W - 1);
  localparam logic [OUT_W-1:0] ALL1 = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] MINP = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};

  logic stall;
  logic adv;

  logic             out_valid_q;
  logic [OUT_W-1:0] dst_q;
  logic [1:0]       flags_q;

  // A full freeze on back-pressure keeps stage alignment trivial; bubbles
  // travel through like real operands.
  assign stall     = out_valid_q && !out_ready;
  assign adv       = !stall;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign flags     = flags_q;

  // ---------------- Stage 1: unpack and classify ----------------
  logic        s1_valid_q;
  logic        s1_sign_q;
  logic [10:0] s1_exp_q;
  logic [52:0] s1_mant_q;
  logic        s1_nan_q;
  logic        s1_inf_q;
  logic        s1_uns_q;
  logic [1:0]  s1_rm_q;

  logic [10:0] in_exp;
  logic [51:0] in_frac;
  logic        in_hidden;

  assign in_exp    = src[62:52];
  assign in_frac   = src[51:0];
  // Denormals and zeros carry a cleared hidden bit; the right-shift path
  // below then drives their magnitude to 0 with sticky = (frac != 0).
  assign in_hidden = (in_exp != 11'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= 11'd0;
      s1_mant_q  <= 53'd0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_rm_q    <= 2'd0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= src[63];
      s1_exp_q   <= in_exp;
      s1_mant_q  <= {in_hidden, in_frac};
      s1_nan_q   <= (in_exp == 11'h7FF) && (in_frac != 52'd0);
      s1_inf_q   <= (in_exp == 11'h7FF) && (in_frac == 52'd0);
      s1_uns_q   <= is_unsigned;
      s1_rm_q    <= rmode;
    end
  end

  // ---------------- Stage 2: align magnitude ----------------
  logic        s2_valid_q;
  logic        s2_sign_q;
  logic [63:0] s2_mag_q;
  logic        s2_guard_q;
  logic        s2_sticky_q;
  logic        s2_povf_q;
  logic        s2_nan_q;
  logic        s2_inf_q;
  logic        s2_uns_q;
  logic [1:0]  s2_rm_q;

  logic [10:0]  lsh;
  logic [10:0]  rsh;
  logic [63:0]  lmag;
  logic [116:0] rext;
  logic [63:0]  s2_mag_d;
  logic         s2_guard_d;
  logic         s2_sticky_d;
  logic         s2_povf_d;

  always_comb begin
    lsh  = s1_exp_q - 11'd1075;
    rsh  = 11'd1075 - s1_exp_q;
    // Only shifts below 12 can keep the 53-bit mantissa under bit 64.
    lmag = {11'd0, s1_mant_q} << lsh[3:0];
    // Right shifts below 64 land the integer part in the top 53 bits and
    // leave the shifted-out bits below for guard and sticky.
    rext = {s1_mant_q, 64'd0} >> rsh[5:0];

    s2_mag_d    = 64'd0;
    s2_guard_d  = 1'b0;
    s2_sticky_d = 1'b0;
    s2_povf_d   = 1'b0;
    if (s1_exp_q >= 11'd1075) begin
      s2_mag_d  = lmag;
      s2_povf_d = (lsh >= 11'd12);
    end else if (rsh >= 11'd64) begin
      s2_sticky_d = (s1_mant_q != 53'd0);
    end else begin
      s2_mag_d    = {11'd0, rext[116:64]};
      s2_guard_d  = rext[63];
      s2_sticky_d = |rext[62:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_mag_q    <= 64'd0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_povf_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_uns_q    <= 1'b0;
      s2_rm_q     <= 2'd0;
    end else if (adv) begin
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_mag_q    <= s2_mag_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      s2_povf_q   <= s2_povf_d;
      s2_nan_q    <= s1_nan_q;
      s2_inf_q    <= s1_inf_q;
      s2_uns_q    <= s1_uns_q;
      s2_rm_q     <= s1_rm_q;
    end
  end

  // ---------------- Stage 3: round, sign, range ----------------
  logic             inc;
  logic             lost;
  logic [65:0]      mag_r;
  logic             oor;
  logic             invalid;
  logic [OUT_W-1:0] dst_d;
  logic [1:0]       flags_d;

  always_comb begin
    lost = s2_guard_q || s2_sticky_q;
    inc  = 1'b0;
    case (s2_rm_q)
      2'b00:   inc = 1'b0;
      2'b01:   inc = s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
      2'b10:   inc = s2_sign_q && lost;
      default: inc = !s2_sign_q && lost;
    endcase

    // Two bits of headroom: the increment on an all-ones magnitude is
    // visible as a range violation rather than wrapping to zero.
    mag_r = {2'b00, s2_mag_q} + {65'd0, inc};

    if (s2_uns_q)
      oor = s2_sign_q ? (mag_r != 66'd0) : (mag_r > UMAX);
    else
      oor = s2_sign_q ? (mag_r > SMIN_MAG) : (mag_r > SMAX);

    invalid = s2_nan_q || s2_inf_q || s2_povf_q || oor;

    if (s2_nan_q)
      dst_d = s2_uns_q ? ALL1 : MINP;
    else if (invalid)
      dst_d = s2_uns_q ? (s2_sign_q ? '0 : ALL1) : (s2_sign_q ? MINP : MAXP);
    else if (s2_sign_q)
      dst_d = ~mag_r[OUT_W-1:0] + OUT_W'(1);
    else
      dst_d = mag_r[OUT_W-1:0];

    flags_d = {invalid, !invalid && lost};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      flags_q     <= 2'b00;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      // Result registers only move with a real operand so the last
      // result stays visible across bubbles.
      if (s2_valid_q) begin
        dst_q   <= dst_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fp_to_int_pipe.sv
// tb/tb_fpu_fp_to_int_pipe.sv - self-checking bench for fpu_fp_to_int_pipe

module tb_fpu_fp_to_int_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] src;
  logic        is_unsigned;
  logic [1:0]  rmode;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] dst32;
  logic [1:0]  flags32;
  logic        in_ready64, out_valid64;
  logic [63:0] dst64;
  logic [1:0]  flags64;

  fpu_fp_to_int_pipe #(.OUT_W(32), .PIPE_ST(3)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .src(src), .is_unsigned(is_unsigned), .rmode(rmode),
    .out_valid(out_valid32), .out_ready(out_ready), .dst(dst32), .flags(flags32)
  );

  fpu_fp_to_int_pipe #(.OUT_W(64), .PIPE_ST(3)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .src(src), .is_unsigned(is_unsigned), .rmode(rmode),
    .out_valid(out_valid64), .out_ready(out_ready), .dst(dst64), .flags(flags64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact value = mant * 2^sh held as 64.128 fixed point, then
  // rounded and range-checked with plain signed arithmetic.
  function automatic void ref_model(input logic [63:0] s, input bit u, input logic [1:0] r,
                                    input int w, output logic [63:0] d, output logic [1:0] fl);
    logic              sign = s[63];
    logic [10:0]       e    = s[62:52];
    logic [51:0]       fr   = s[51:0];
    logic [63:0]       all1 = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    logic [63:0]       minp = 64'd1 << (w - 1);
    logic [63:0]       maxp = all1 >> 1;
    logic [52:0]       mant;
    int                sh;
    logic [191:0]      fixed;
    logic [63:0]       ip;
    logic [127:0]      fp;
    logic              fnz, gt, eq;
    logic signed [67:0] n, v, maxv, minv;
    mant = (e == 11'd0) ? {1'b0, fr} : {1'b1, fr};
    sh   = (e == 11'd0) ? -1074 : int'(e) - 1075;
    if (e == 11'h7FF && fr != 52'd0) begin
      d = u ? all1 : minp; fl = 2'b10; return;
    end
    if (e == 11'h7FF || sh >= 12) begin
      d = u ? (sign ? 64'd0 : all1) : (sign ? minp : maxp); fl = 2'b10; return;
    end
    if (sh < -120) begin
      ip = 64'd0; fnz = (mant != 53'd0); gt = 1'b0; eq = 1'b0;
    end else begin
      fixed = 192'(mant) << (sh + 128);
      ip  = fixed[191:128];
      fp  = fixed[127:0];
      fnz = (fp != 128'd0);
      gt  = fp > (128'd1 << 127);
      eq  = fp == (128'd1 << 127);
    end
    n = 68'(ip);
    case (r)
      2'b00:   n = n;
      2'b01:   n = n + 68'(gt || (eq && ip[0]));
      2'b10:   n = n + 68'(sign && fnz);
      default: n = n + 68'(!sign && fnz);
    endcase
    v    = sign ? -n : n;
    maxv = u ? ((68'sd1 <<< w) - 68'sd1) : ((68'sd1 <<< (w - 1)) - 68'sd1);
    minv = u ? 68'sd0 : -(68'sd1 <<< (w - 1));
    if (v > maxv) begin
      d = u ? all1 : maxp; fl = 2'b10;
    end else if (v < minv) begin
      d = u ? 64'd0 : minp; fl = 2'b10;
    end else begin
      d = v[63:0] & all1; fl = {1'b0, fnz};
    end
  endfunction

  typedef struct {
    logic [63:0] s;
    bit          u;
    logic [1:0]  r;
    int          acc;
    int          wsel;
    logic [63:0] ed;
    logic [1:0]  ef;
  } item_t;

  item_t q[$];

  // Fixed expectations for directed operands, attached to whichever width
  // wsel names; the other width is checked against the model.
  int          cur_wsel = 0;
  logic [63:0] cur_ed   = 64'd0;
  logic [1:0]  cur_ef   = 2'd0;

  int  adv_cnt   = 0;
  int  cyc_cnt   = 0;
  int  win_start = 1000000;
  bit  rand_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc_cnt = cyc_cnt + 1;
    out_ready = !((cyc_cnt >= win_start) && (cyc_cnt < win_start + 4)) &&
                (!rand_mode || ($urandom_range(0, 9) < 7));
  end

  item_t       mit;
  logic [63:0] md;
  logic [1:0]  mf;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      check_eq("in_ready32", {63'd0, in_ready32}, {63'd0, !(out_valid32 && !out_ready)});
      check_eq("in_ready64", {63'd0, in_ready64}, {63'd0, !(out_valid64 && !out_ready)});
      if ((out_valid32 || out_valid64) && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", {63'd0, out_valid32 | out_valid64}, 64'd0);
        end else begin
          mit = q.pop_front();
          check_eq("ov32", {63'd0, out_valid32}, 64'd1);
          check_eq("ov64", {63'd0, out_valid64}, 64'd1);
          check_eq("latency", 64'(adv_cnt), 64'(mit.acc + 3));
          ref_model(mit.s, mit.u, mit.r, 32, md, mf);
          if (mit.wsel == 32) begin md = mit.ed; mf = mit.ef; end
          check_eq("dst32", {32'd0, dst32}, md);
          check_eq("flags32", {62'd0, flags32}, {62'd0, mf});
          ref_model(mit.s, mit.u, mit.r, 64, md, mf);
          if (mit.wsel == 64) begin md = mit.ed; mf = mit.ef; end
          check_eq("dst64", dst64, md);
          check_eq("flags64", {62'd0, flags64}, {62'd0, mf});
        end
      end
      if (in_valid && in_ready32)
        q.push_back('{s: src, u: is_unsigned, r: rmode, acc: adv_cnt,
                      wsel: cur_wsel, ed: cur_ed, ef: cur_ef});
      if (!(out_valid32 && !out_ready))
        adv_cnt = adv_cnt + 1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the operand is taken.
  task automatic send(input logic [63:0] s, input bit u, input logic [1:0] r,
                      input int wsel, input logic [63:0] ed, input logic [1:0] ef);
    int waited = 0;
    src = s; is_unsigned = u; rmode = r;
    cur_wsel = wsel; cur_ed = ed; cur_ef = ef;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready32 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check_eq("accept_timeout", 64'(waited), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cur_wsel = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("drained", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_src();
    logic [63:0] rr = {$urandom, $urandom};
    logic [10:0] e;
    logic [51:0] f = rr[51:0];
    int k = $urandom_range(0, 9);
    e = 11'(1015 + $urandom_range(0, 72));
    if (k == 6) begin
      e = 11'd0;
      if ($urandom_range(0, 1) == 0) f = 52'd0;
    end else if (k == 7) begin
      e = 11'h7FF;
      if ($urandom_range(0, 1) == 0) f = 52'd0;
    end else if (k == 8) begin
      f = f & (52'hF_FFFF_FFFF_FFFF << $urandom_range(0, 52));
    end else if (k == 9) begin
      e = rr[62:52];
    end
    return {rr[63], e, f};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; src = 64'd0; is_unsigned = 1'b0;
    rmode = 2'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_eq("rst_ov32",    {63'd0, out_valid32}, 64'd0);
    check_eq("rst_ov64",    {63'd0, out_valid64}, 64'd0);
    check_eq("rst_dst32",   {32'd0, dst32}, 64'd0);
    check_eq("rst_dst64",   dst64, 64'd0);
    check_eq("rst_flags32", {62'd0, flags32}, 64'd0);
    check_eq("rst_flags64", {62'd0, flags64}, 64'd0);
    check_eq("rst_ir32",    {63'd0, in_ready32}, 64'd1);
    check_eq("rst_ir64",    {63'd0, in_ready64}, 64'd1);
    @(posedge clk); #1;

    // Directed back-to-back stream with a 4-cycle consumer stall.
    win_start = cyc_cnt + 5;
    send(64'h3FF8000000000000, 1'b0, 2'b01, 32, 64'h2,        2'b01);
    send(64'h4004000000000000, 1'b0, 2'b01, 32, 64'h2,        2'b01);
    send(64'hBFF8000000000000, 1'b0, 2'b00, 32, 64'hFFFFFFFF, 2'b01);
    send(64'h41E0000000000000, 1'b0, 2'b00, 32, 64'h7FFFFFFF, 2'b10);
    send(64'hC1E0000000000000, 1'b0, 2'b00, 32, 64'h80000000, 2'b00);
    send(64'h7FF8000000000000, 1'b0, 2'b00, 32, 64'h80000000, 2'b10);
    send(64'hBFD0000000000000, 1'b1, 2'b11, 64, 64'h0,        2'b01);
    send(64'hBFF0000000000000, 1'b1, 2'b00, 64, 64'h0,        2'b10);
    send(64'h43EFFFFFFFFFFFFF, 1'b1, 2'b00, 64, 64'hFFFFFFFFFFFFF800, 2'b00);
    send(64'h8000000000000001, 1'b0, 2'b10, 64, 64'hFFFFFFFFFFFFFFFF, 2'b01);
    send(64'h8000000000000001, 1'b1, 2'b10, 64, 64'h0,        2'b10);
    send(64'hBFD999999999999A, 1'b1, 2'b00, 64, 64'h0,        2'b01);
    send(64'h8000000000000000, 1'b0, 2'b01, 64, 64'h0,        2'b00);
    send(64'hFFF0000000000000, 1'b1, 2'b00, 64, 64'h0,        2'b10);
    send(64'h7FF0000000000000, 1'b0, 2'b00, 32, 64'h7FFFFFFF, 2'b10);
    drain();

    // Reset with three operands in flight.
    send(rand_src(), 1'b0, 2'b01, 0, 64'd0, 2'd0);
    send(rand_src(), 1'b1, 2'b10, 0, 64'd0, 2'd0);
    send(rand_src(), 1'b0, 2'b11, 0, 64'd0, 2'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_ov32",  {63'd0, out_valid32}, 64'd0);
    check_eq("midrst_ov64",  {63'd0, out_valid64}, 64'd0);
    check_eq("midrst_dst64", dst64, 64'd0);
    @(posedge clk); #1;
    send(64'h3FF8000000000000, 1'b0, 2'b01, 32, 64'h2, 2'b01);
    drain();

    // Random sweep with random gaps and random back-pressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(rand_src(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 64'd0, 2'd0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
